duft_ap_ctrl_hs_burst: RTL

Parametrised burst-capable successor to the DUFT single-word ap_ctrl_hs wrapper. Sits between an HLS-style ap_ctrl_hs host and the prewrapped DUFT core's address/message port pair. One accepted command moves 1..2^LEN_W words at consecutive core addresses, with per-beat valid/ready data handshakes. The block also reports a beat count and an error flag on completion.

---
 rtl/duft_ap_ctrl_hs_burst_if.sv | 39 +++
 rtl/duft_ap_ctrl_hs_burst.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/duft_ap_ctrl_hs_burst_if.sv
// Host and core signal bundle for duft_ap_ctrl_hs_burst.
// The slave modport is the wrapper's view and the master modport is the environment's view.
interface duft_ap_ctrl_hs_burst_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic              ap_start;
    logic              rd_wr;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  burst_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              ap_idle;
    logic              ap_ready;
    logic              ap_done;
    logic [LEN_W:0]    ap_return;
    logic              ap_err;
    logic [ADDR_W-1:0] core_rd_addr;
    logic [ADDR_W-1:0] core_wr_addr;
    logic [DATA_W-1:0] core_rd_msg;
    logic [DATA_W-1:0] core_wr_msg;

    modport slave (
        input  ap_start, rd_wr, addr, burst_len, wr_data, wr_valid, rd_ready, core_rd_msg,
        output wr_ready, rd_data, rd_valid, ap_idle, ap_ready, ap_done, ap_return, ap_err,
               core_rd_addr, core_wr_addr, core_wr_msg
    );

    modport master (
        output ap_start, rd_wr, addr, burst_len, wr_data, wr_valid, rd_ready, core_rd_msg,
        input  wr_ready, rd_data, rd_valid, ap_idle, ap_ready, ap_done, ap_return, ap_err,
               core_rd_addr, core_wr_addr, core_wr_msg
    );
endinterface

// File: rtl/duft_ap_ctrl_hs_burst.sv
// Burst ap_ctrl_hs wrapper in front of the DUFT core address/message port pair.
// Defining DUFT_HS_TIMEOUT_EN adds a stall timeout that ends a stuck burst with an error.
module duft_ap_ctrl_hs_burst #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 8,
    parameter int ADDR_INC    = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   ap_rst_n,
    duft_ap_ctrl_hs_burst_if.slave bus
);
    typedef enum logic [2:0] {
        RST, IDLE, RD_ISSUE, RD_PUSH, WR_WAIT, WR_ISSUE, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] SENTINEL = '1;
    localparam logic [ADDR_W-1:0] INC      = ADDR_W'(ADDR_INC);

    state_t            state_reg;
    logic [ADDR_W-1:0] cur_addr_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W:0]    idx_reg;
    logic              err_reg;
    logic              wr_ready_reg;
    logic              rd_valid_reg;
    logic              ap_done_reg;
    logic              ap_err_reg;
    logic [LEN_W:0]    ap_return_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic [DATA_W-1:0] core_wr_msg_reg;
    logic [ADDR_W-1:0] core_rd_addr_reg;
    logic [ADDR_W-1:0] core_wr_addr_reg;

    logic              cur_sentinel;
    logic              last_beat;
    logic [ADDR_W-1:0] next_addr;
    logic [LEN_W:0]    idx_inc;
    logic              stall_expire;

    assign cur_sentinel = (cur_addr_reg == SENTINEL);
    assign last_beat    = (idx_reg == {1'b0, len_reg});
    assign next_addr    = cur_addr_reg + INC;
    assign idx_inc      = idx_reg + (LEN_W+1)'(1);

`ifdef DUFT_HS_TIMEOUT_EN
    localparam logic [31:0] STALL_LAST = 32'(TIMEOUT_CYC - 1);
    logic [31:0] stall_reg;

    // Counts consecutive cycles a wait state goes without its handshake.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stall_reg <= '0;
        end else if ((state_reg == RD_PUSH && !bus.rd_ready) ||
                     (state_reg == WR_WAIT && !bus.wr_valid)) begin
            stall_reg <= stall_reg + 32'd1;
        end else begin
            stall_reg <= '0;
        end
    end

    assign stall_expire = (stall_reg == STALL_LAST);
`else
    // Without the counter the limit is inert; only a nonsensical negative limit would differ.
    assign stall_expire = (TIMEOUT_CYC < 0);
`endif

    // A sentinel beat needs no special address path: the computed address already
    // equals the idle all-ones value, so driving it looks exactly like no access.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg        <= RST;
            cur_addr_reg     <= '0;
            len_reg          <= '0;
            idx_reg          <= '0;
            err_reg          <= 1'b0;
            wr_ready_reg     <= 1'b0;
            rd_valid_reg     <= 1'b0;
            ap_done_reg      <= 1'b0;
            ap_err_reg       <= 1'b0;
            ap_return_reg    <= '0;
            rd_data_reg      <= '0;
            core_wr_msg_reg  <= '0;
            core_rd_addr_reg <= SENTINEL;
            core_wr_addr_reg <= SENTINEL;
        end else begin
            ap_done_reg <= 1'b0;
            case (state_reg)
                RST: state_reg <= IDLE;

                IDLE: begin
                    if (bus.ap_start) begin
                        cur_addr_reg  <= bus.addr;
                        len_reg       <= bus.burst_len;
                        idx_reg       <= '0;
                        err_reg       <= 1'b0;
                        ap_return_reg <= '0;
                        ap_err_reg    <= 1'b0;
                        if (bus.rd_wr) begin
                            state_reg        <= RD_ISSUE;
                            core_rd_addr_reg <= bus.addr;
                        end else begin
                            state_reg    <= WR_WAIT;
                            wr_ready_reg <= 1'b1;
                        end
                    end
                end

                RD_ISSUE: begin
                    rd_data_reg      <= cur_sentinel ? '0 : bus.core_rd_msg;
                    err_reg          <= err_reg | cur_sentinel;
                    core_rd_addr_reg <= SENTINEL;
                    rd_valid_reg     <= 1'b1;
                    state_reg        <= RD_PUSH;
                end

                RD_PUSH: begin
                    if (bus.rd_ready) begin
                        rd_valid_reg <= 1'b0;
                        idx_reg      <= idx_inc;
                        cur_addr_reg <= next_addr;
                        if (last_beat) begin
                            state_reg     <= DONE;
                            ap_done_reg   <= 1'b1;
                            ap_return_reg <= idx_inc;
                            ap_err_reg    <= err_reg;
                        end else begin
                            state_reg        <= RD_ISSUE;
                            core_rd_addr_reg <= next_addr;
                        end
                    end else if (stall_expire) begin
                        rd_valid_reg  <= 1'b0;
                        state_reg     <= DONE;
                        ap_done_reg   <= 1'b1;
                        ap_return_reg <= idx_reg;
                        ap_err_reg    <= 1'b1;
                    end
                end

                WR_WAIT: begin
                    if (bus.wr_valid) begin
                        wr_ready_reg     <= 1'b0;
                        core_wr_addr_reg <= cur_addr_reg;
                        core_wr_msg_reg  <= cur_sentinel ? '0 : bus.wr_data;
                        err_reg          <= err_reg | cur_sentinel;
                        state_reg        <= WR_ISSUE;
                    end else if (stall_expire) begin
                        wr_ready_reg  <= 1'b0;
                        state_reg     <= DONE;
                        ap_done_reg   <= 1'b1;
                        ap_return_reg <= idx_reg;
                        ap_err_reg    <= 1'b1;
                    end
                end

                WR_ISSUE: begin
                    core_wr_addr_reg <= SENTINEL;
                    core_wr_msg_reg  <= '0;
                    idx_reg          <= idx_inc;
                    cur_addr_reg     <= next_addr;
                    if (last_beat) begin
                        state_reg     <= DONE;
                        ap_done_reg   <= 1'b1;
                        ap_return_reg <= idx_inc;
                        ap_err_reg    <= err_reg;
                    end else begin
                        state_reg    <= WR_WAIT;
                        wr_ready_reg <= 1'b1;
                    end
                end

                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.ap_idle      = (state_reg == IDLE) && !bus.ap_start;
    assign bus.ap_done      = ap_done_reg;
    assign bus.ap_ready     = ap_done_reg;
    assign bus.ap_return    = ap_return_reg;
    assign bus.ap_err       = ap_err_reg;
    assign bus.wr_ready     = wr_ready_reg;
    assign bus.rd_valid     = rd_valid_reg;
    assign bus.rd_data      = rd_data_reg;
    assign bus.core_rd_addr = core_rd_addr_reg;
    assign bus.core_wr_addr = core_wr_addr_reg;
    assign bus.core_wr_msg  = core_wr_msg_reg;
endmodule
